// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, execute-side training and stats
module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       PCF,
    output logic              PredictionF,
    output logic [31:0]       PredictedPCF,
    input  logic              UpdateE,
    input  logic [31:0]       PCE,
    input  logic              TakenE,
    input  logic [31:0]       TargetE,
    input  logic              MispredictE,
    output logic [STAT_W-1:0] HitCount,
    output logic [STAT_W-1:0] MispredictCount
);
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] idx_f;
    logic [INDEX_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0]   tag_f;
    logic [TAG_BITS-1:0]   tag_e;
    logic                  hit_f;
    logic                  hit_e;
    logic                  unused_pc_bits;

    assign idx_f = PCF[INDEX_BITS+1:2];
    assign tag_f = PCF[31:INDEX_BITS+2];
    assign idx_e = PCE[INDEX_BITS+1:2];
    assign tag_e = PCE[31:INDEX_BITS+2];

    // Instructions are word aligned, so the low PC bits carry no information.
    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

    // Lookup reads the table as it stands; an update this cycle lands at the edge.
    assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e        = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign PredictionF  = hit_f && ctr_q[idx_f][1];
    assign PredictedPCF = PredictionF ? target_q[idx_f] : (PCF + 32'd4);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            HitCount        <= '0;
            MispredictCount <= '0;
        end else begin
            if (UpdateE) begin
                if (hit_e) begin
                    if (TakenE) begin
                        target_q[idx_e] <= TargetE;
                        if (ctr_q[idx_e] != 2'b11) begin
                            ctr_q[idx_e] <= ctr_q[idx_e] + 2'b01;
                        end
                    end else if (ctr_q[idx_e] != 2'b00) begin
                        ctr_q[idx_e] <= ctr_q[idx_e] - 2'b01;
                    end
                end else if (TakenE) begin
                    valid_q[idx_e]  <= 1'b1;
                    tag_q[idx_e]    <= tag_e;
                    target_q[idx_e] <= TargetE;
                    ctr_q[idx_e]    <= 2'b10;
                end
            end
            if (hit_f && (HitCount != '1)) begin
                HitCount <= HitCount + STAT_W'(1);
            end
            if (UpdateE && MispredictE && (MispredictCount != '1)) begin
                MispredictCount <= MispredictCount + STAT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        PredictionF;
    logic [31:0] PredictedPCF;
    logic        UpdateE;
    logic [31:0] PCE;
    logic        TakenE;
    logic [31:0] TargetE;
    logic        MispredictE;
    logic [15:0] HitCount;
    logic [15:0] MispredictCount;

    int total = 0;
    int bad   = 0;

    branch_predictor #(.INDEX_BITS(4), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .PredictionF(PredictionF),
        .PredictedPCF(PredictedPCF), .UpdateE(UpdateE), .PCE(PCE),
        .TakenE(TakenE), .TargetE(TargetE), .MispredictE(MispredictE),
        .HitCount(HitCount), .MispredictCount(MispredictCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic misp);
        UpdateE     = 1'b1;
        PCE         = pc;
        TakenE      = taken;
        TargetE     = tgt;
        MispredictE = misp;
        tick();
        UpdateE     = 1'b0;
        MispredictE = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; PCF = 32'h40; UpdateE = 1'b0; PCE = '0;
        TakenE = 1'b0; TargetE = '0; MispredictE = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("rst_pred", {31'd0, PredictionF}, 32'd0);
        chk("rst_ppc", PredictedPCF, 32'h44);
        chk("rst_hc", {16'd0, HitCount}, 32'd0);
        chk("rst_mc", {16'd0, MispredictCount}, 32'd0);
        tick();
        chk("miss_hc", {16'd0, HitCount}, 32'd0);

        // Allocate 0x40 -> 0x100 while looking it up: the lookup still sees the miss.
        UpdateE = 1'b1; PCE = 32'h40; TakenE = 1'b1; TargetE = 32'h100;
        #1;
        chk("alloc_same_cycle_pred", {31'd0, PredictionF}, 32'd0);
        tick();
        UpdateE = 1'b0;
        chk("alloc_pred", {31'd0, PredictionF}, 32'd1);
        chk("alloc_ppc", PredictedPCF, 32'h100);
        tick();
        chk("alloc_hc", {16'd0, HitCount}, 32'd1);

        PCF = 32'h1000;
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        PCF = 32'h40; #1;
        chk("ctr01_pred", {31'd0, PredictionF}, 32'd0);
        chk("ctr01_ppc", PredictedPCF, 32'h44);
        PCF = 32'h1000;
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        PCF = 32'h40; #1;
        chk("ctr00_pred", {31'd0, PredictionF}, 32'd0);
        chk("ctr00_ppc", PredictedPCF, 32'h44);
        tick();
        chk("ctr00_still_hit", {16'd0, HitCount}, 32'd2);
        // From a held 00, one taken step reaches 01 (not taken), two reach 10 (taken).
        PCF = 32'h1000;
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        PCF = 32'h40; #1;
        chk("sat_low_pred", {31'd0, PredictionF}, 32'd0);
        PCF = 32'h1000;
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        PCF = 32'h40; #1;
        chk("retrain_pred", {31'd0, PredictionF}, 32'd1);
        chk("retrain_ppc", PredictedPCF, 32'h100);

        PCF = 32'h1000;
        upd(32'h80, 1'b1, 32'h200, 1'b0);
        PCF = 32'h40; #1;
        chk("alias_old_pred", {31'd0, PredictionF}, 32'd0);
        chk("alias_old_ppc", PredictedPCF, 32'h44);
        PCF = 32'h80; #1;
        chk("alias_new_pred", {31'd0, PredictionF}, 32'd1);
        chk("alias_new_ppc", PredictedPCF, 32'h200);

        // 0x80 ctr 10 -> 01 with a same-cycle lookup.
        UpdateE = 1'b1; PCE = 32'h80; TakenE = 1'b0; TargetE = 32'h0;
        #1;
        chk("same_cycle_old_pred", {31'd0, PredictionF}, 32'd1);
        chk("same_cycle_old_ppc", PredictedPCF, 32'h200);
        tick();
        UpdateE = 1'b0;
        chk("same_cycle_new_pred", {31'd0, PredictionF}, 32'd0);
        chk("same_cycle_new_ppc", PredictedPCF, 32'h84);
        chk("same_cycle_hc", {16'd0, HitCount}, 32'd3);

        PCF = 32'hFFFF_FFFC; #1;
        chk("wrap_ppc", PredictedPCF, 32'h0);

        PCF = 32'h1000;
        rst = 1'b0;
        UpdateE = 1'b1; PCE = 32'h80; TakenE = 1'b1; TargetE = 32'h300; MispredictE = 1'b1;
        tick();
        rst = 1'b1; UpdateE = 1'b0; MispredictE = 1'b0;
        PCF = 32'h80; #1;
        chk("rst_upd_pred80", {31'd0, PredictionF}, 32'd0);
        chk("rst_upd_ppc80", PredictedPCF, 32'h84);
        PCF = 32'h40; #1;
        chk("rst_upd_pred40", {31'd0, PredictionF}, 32'd0);
        chk("rst_upd_mc", {16'd0, MispredictCount}, 32'd0);
        tick();
        chk("rst_upd_hc", {16'd0, HitCount}, 32'd0);

        PCF = 32'h1000;
        upd(32'h1000, 1'b0, 32'h0, 1'b1);
        upd(32'h1000, 1'b0, 32'h0, 1'b0);
        upd(32'h1000, 1'b0, 32'h0, 1'b1);
        upd(32'h1000, 1'b0, 32'h0, 1'b1);
        upd(32'h1000, 1'b0, 32'h0, 1'b0);
        upd(32'h1000, 1'b0, 32'h0, 1'b1);
        upd(32'h1000, 1'b0, 32'h0, 1'b0);
        upd(32'h1000, 1'b0, 32'h0, 1'b1);
        chk("stats_mc5", {16'd0, MispredictCount}, 32'd5);
        MispredictE = 1'b1;
        tick();
        MispredictE = 1'b0;
        chk("stats_no_update", {16'd0, MispredictCount}, 32'd5);
        for (int i = 0; i < 65530; i++) begin
            upd(32'h1000, 1'b0, 32'h0, 1'b1);
        end
        chk("stats_mc_max", {16'd0, MispredictCount}, 32'h0000_FFFF);
        upd(32'h1000, 1'b0, 32'h0, 1'b1);
        chk("stats_mc_sat", {16'd0, MispredictCount}, 32'h0000_FFFF);
        chk("stats_hc", {16'd0, HitCount}, 32'd0);
        chk("stats_table_untouched", {31'd0, PredictionF}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor that produces the PredictionE / PredictedPCE_E pair carried down the pipeline to the execute stage.
- Fetch-side lookup: direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Execute-side update: takes resolved branch outcome and target from the execute stage and trains the table.
- Keeps saturating lookup-hit and mispredict statistics counters for performance debug.

Parameters:
- INDEX_BITS, 4, log2 of entry count; index = PC[INDEX_BITS+1:2].
- TAG_BITS, 32-INDEX_BITS-2 (derived, not overridable), tag = PC[31:INDEX_BITS+2].
- STAT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- PCF  in  32  fetch PC to look up.
- PredictionF  out  1  predict taken.
- PredictedPCF  out  32  predicted next PC.
- UpdateE  in  1  a conditional branch is resolving in execute this cycle.
- PCE  in  32  PC of the resolving branch.
- TakenE  in  1  actual outcome (1 = taken).
- TargetE  in  32  actual branch target (PCTargetE).
- MispredictE  in  1  execute flagged misprediction (FlushE); counted only when UpdateE=1.
- HitCount  out  STAT_W  lookups that hit a valid entry.
- MispredictCount  out  STAT_W  updates with MispredictE=1.

Behaviour:
- Entry state: valid (1), tag (TAG_BITS), target (32), ctr (2). Array of 2^INDEX_BITS entries.
- Reset (rst=0 at rising edge):
  - Every valid cleared, every ctr set to 2'b01, every target and tag cleared.
  - HitCount and MispredictCount set to 0.
  - The update port is ignored that cycle.
- Outputs after reset: PredictionF=0, PredictedPCF=PCF+4, HitCount=0, MispredictCount=0.
- Lookup (combinational from current table contents, zero latency):
  - hit = valid[idxF] && tag[idxF]==PCF tag.
  - PredictionF = hit && ctr[idxF][1].
  - PredictedPCF = PredictionF ? target[idxF] : PCF+4. Addition is modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- Update (registered, takes effect at the rising edge when UpdateE=1 and rst=1):
  - Hit, taken: ctr saturating increment (max 2'b11); target <= TargetE.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate / overwrite the entry: valid<=1, tag<=PCE tag, target<=TargetE, ctr<=2'b10.
  - Miss, not taken: no table change.
- Simultaneous lookup and update of the same index in one cycle:
  - Lookup returns pre-update contents; there is no bypass.
  - The new contents are visible from the next cycle.
- HitCount: +1 per cycle in which the lookup hits (rst=1). Saturates at all-ones; never wraps.
- MispredictCount: +1 per cycle with UpdateE && MispredictE (rst=1). Saturates at all-ones.
- UpdateE=0: TakenE, TargetE, MispredictE and PCE are don't-care, and no state changes.
- Reset asserted mid-operation: the pending update is dropped, the table is cleared, and lookup returns not-taken from the next cycle.

Test Plan:
- Reset, then PCF=0x00000040 → PredictionF=0, PredictedPCF=0x00000044, HitCount stays 0.
- UpdateE, PCE=0x40, TakenE=1, TargetE=0x100 → next cycle PCF=0x40 gives PredictionF=1, PredictedPCF=0x100, and HitCount increments.
- Continue from the previous test with two not-taken updates to 0x40 → ctr 10→01→00. Lookup then gives PredictionF=0, PredictedPCF=0x44, and the entry is still a hit. A third not-taken update holds ctr at 00.
- Aliasing: entry 0x40 valid; taken update for PCE=0x80 (same index 0, different tag) with TargetE=0x200 → 0x40 now misses (predicts 0x44), and 0x80 predicts 0x200.
- Same-cycle update and lookup of index 0 → lookup shows the old value that cycle and the new value the next cycle. rst=0 asserted alongside UpdateE → update discarded and all lookups miss.
- Stats: drive 5 updates with MispredictE=1 and 3 with MispredictE=0 → MispredictCount=5. Force the counter to 0xFFFF and add one more mispredict → it stays at 0xFFFF.
